mem_stage_ws: RTL and testbench

//  Parametrised RV32 MEM pipeline stage: EX/MEM inputs -> data memory -> MEM/WB register.

---
 rtl/mem_stage_ws.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_stage_ws.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ws.sv
// mem_stage_ws: RV32 MEM stage with sized loads/stores and optional wait states.
// Optional misaligned-access detection: define MEM_MISALIGN_CHECK_EN.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   EX_MEM_mem_to_reg/reg_write       WB control from EX/MEM
//   EX_MEM_mem_read/mem_write         load / store request
//   EX_MEM_funct3                     access size and sign (RV32 encoding)
//   EX_MEM_alu_out                    byte address or ALU result
//   EX_MEM_dataB                      store data
//   EX_MEM_rd                         destination register
//   mem_stall                         freeze IF..EX, hold EX/MEM
//   mem_data                          combinational load result
//   MEM_WB_*                          registered MEM/WB bundle
module mem_stage_ws #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter bit INIT_IDX    = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            EX_MEM_mem_to_reg,
    input  logic            EX_MEM_reg_write,
    input  logic            EX_MEM_mem_read,
    input  logic            EX_MEM_mem_write,
    input  logic [2:0]      EX_MEM_funct3,
    input  logic [XLEN-1:0] EX_MEM_alu_out,
    input  logic [XLEN-1:0] EX_MEM_dataB,
    input  logic [4:0]      EX_MEM_rd,
    output logic            mem_stall,
    output logic [XLEN-1:0] mem_data,
    output logic            MEM_WB_reg_write,
    output logic            MEM_WB_mem_to_reg,
    output logic [XLEN-1:0] MEM_WB_mem_data,
    output logic [XLEN-1:0] MEM_WB_alu_out,
    output logic [4:0]      MEM_WB_rd,
    output logic            MEM_WB_misalign
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0]   mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] widx;
    logic [1:0]        lane;
    logic [XLEN-1:0]   rword;
    logic [7:0]        bsel;
    logic [15:0]       hsel;
    logic [XLEN-1:0]   load_val;
    logic [3:0]        be;
    logic [XLEN-1:0]   wdata;
    logic              misalign;
    logic              access;
    logic              commit;
    logic              stall_raw;
    logic              unused_addr;

    // Address bits above the memory wrap silently.
    assign unused_addr = ^EX_MEM_alu_out[XLEN-1:ADDR_W+2];

    assign widx  = EX_MEM_alu_out[ADDR_W+1:2];
    assign lane  = EX_MEM_alu_out[1:0];
    assign rword = mem[widx];

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (EX_MEM_mem_read &&
            (EX_MEM_funct3 == 3'b001 || EX_MEM_funct3 == 3'b101) &&
            lane[0])
            misalign = 1'b1;
        if (EX_MEM_mem_write && EX_MEM_funct3 == 3'b001 && lane[0])
            misalign = 1'b1;
        if ((EX_MEM_mem_read || EX_MEM_mem_write) &&
            EX_MEM_funct3 == 3'b010 && lane != 2'b00)
            misalign = 1'b1;
    end
`else
    assign misalign = 1'b0;
`endif

    // Misaligned accesses never touch memory, so they take no wait states.
    assign access = (EX_MEM_mem_read | EX_MEM_mem_write) & ~misalign;

    always_comb begin
        bsel = 8'h00;
        unique case (lane)
            2'd0: bsel = rword[7:0];
            2'd1: bsel = rword[15:8];
            2'd2: bsel = rword[23:16];
            2'd3: bsel = rword[31:24];
            default: bsel = 8'h00;
        endcase
    end

    assign hsel = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        load_val = '0;
        unique case (EX_MEM_funct3)
            3'b000:  load_val = {{24{bsel[7]}}, bsel};
            3'b001:  load_val = {{16{hsel[15]}}, hsel};
            3'b010:  load_val = rword;
            3'b100:  load_val = {24'h0, bsel};
            3'b101:  load_val = {16'h0, hsel};
            default: load_val = '0;
        endcase
    end

    assign mem_data = (EX_MEM_mem_read && !misalign) ? load_val : '0;

    // Store data is replicated across lanes; byte enables pick the target.
    always_comb begin
        be    = 4'b0000;
        wdata = '0;
        unique case (EX_MEM_funct3)
            3'b000: begin
                be    = 4'b0001 << lane;
                wdata = {4{EX_MEM_dataB[7:0]}};
            end
            3'b001: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{EX_MEM_dataB[15:0]}};
            end
            3'b010: begin
                be    = 4'b1111;
                wdata = EX_MEM_dataB;
            end
            default: begin
                be    = 4'b0000;
                wdata = '0;
            end
        endcase
        if (!EX_MEM_mem_write || misalign)
            be = 4'b0000;
    end

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign stall_raw = 1'b0;
            assign commit    = 1'b1;
        end else begin : g_wait
            localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

            typedef enum logic {
                S_IDLE,
                S_WAIT
            } state_t;

            state_t           state;
            state_t           state_n;
            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_n;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= state_n;
                    cnt   <= cnt_n;
                end
            end

            always_comb begin
                state_n   = state;
                cnt_n     = cnt;
                stall_raw = 1'b0;
                commit    = 1'b0;
                unique case (state)
                    S_IDLE: begin
                        if (access) begin
                            stall_raw = 1'b1;
                            cnt_n     = CNT_W'(WAIT_CYCLES - 1);
                            state_n   = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt != '0) begin
                            stall_raw = 1'b1;
                            cnt_n     = cnt - CNT_W'(1);
                        end else begin
                            commit  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                    default: begin
                        state_n = S_IDLE;
                    end
                endcase
            end
        end
    endgenerate

    // Stall is held low while reset is asserted, even with a request pending.
    assign mem_stall = stall_raw & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= INIT_IDX ? XLEN'(i) : '0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            MEM_WB_reg_write  <= 1'b0;
            MEM_WB_mem_to_reg <= 1'b0;
            MEM_WB_mem_data   <= '0;
            MEM_WB_alu_out    <= '0;
            MEM_WB_rd         <= '0;
            MEM_WB_misalign   <= 1'b0;
        end else if (stall_raw) begin
            MEM_WB_reg_write  <= 1'b0;
            MEM_WB_mem_to_reg <= 1'b0;
            MEM_WB_mem_data   <= '0;
            MEM_WB_alu_out    <= '0;
            MEM_WB_rd         <= '0;
            MEM_WB_misalign   <= 1'b0;
        end else begin
            MEM_WB_reg_write  <= EX_MEM_reg_write & ~misalign;
            MEM_WB_mem_to_reg <= EX_MEM_mem_to_reg;
            MEM_WB_mem_data   <= mem_data;
            MEM_WB_alu_out    <= EX_MEM_alu_out;
            MEM_WB_rd         <= EX_MEM_rd;
            MEM_WB_misalign   <= misalign;
        end
    end

endmodule

// File: tb/tb_mem_stage_ws.sv
// tb_mem_stage_ws: table-driven bench for mem_stage_ws.
// Runs a zero-wait instance and a two-wait-state instance side by side.
module tb_mem_stage_ws;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        m2r, rw, rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, dat;
    logic [4:0]  rdst;

    logic        s0, s2;
    logic [31:0] md0, md2;
    logic        rw0, m2r0, mis0, rw2, m2r2, mis2;
    logic [31:0] wd0, alu0, wd2, alu2;
    logic [4:0]  rd0, rd2;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] data;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mis;
    } wb_t;

    typedef struct {
        logic        r;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] exp;
        logic        xmis;
        logic        xrw;
    } vec_t;

    wb_t wb0, wb2;
    assign wb0 = {rw0, m2r0, wd0, alu0, rd0, mis0};
    assign wb2 = {rw2, m2r2, wd2, alu2, rd2, mis2};

    mem_stage_ws #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .EX_MEM_mem_to_reg(m2r), .EX_MEM_reg_write(rw),
        .EX_MEM_mem_read(rd), .EX_MEM_mem_write(wr),
        .EX_MEM_funct3(f3), .EX_MEM_alu_out(addr),
        .EX_MEM_dataB(dat), .EX_MEM_rd(rdst),
        .mem_stall(s0), .mem_data(md0),
        .MEM_WB_reg_write(rw0), .MEM_WB_mem_to_reg(m2r0),
        .MEM_WB_mem_data(wd0), .MEM_WB_alu_out(alu0),
        .MEM_WB_rd(rd0), .MEM_WB_misalign(mis0)
    );

    mem_stage_ws #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .EX_MEM_mem_to_reg(m2r), .EX_MEM_reg_write(rw),
        .EX_MEM_mem_read(rd), .EX_MEM_mem_write(wr),
        .EX_MEM_funct3(f3), .EX_MEM_alu_out(addr),
        .EX_MEM_dataB(dat), .EX_MEM_rd(rdst),
        .mem_stall(s2), .mem_data(md2),
        .MEM_WB_reg_write(rw2), .MEM_WB_mem_to_reg(m2r2),
        .MEM_WB_mem_data(wd2), .MEM_WB_alu_out(alu2),
        .MEM_WB_rd(rd2), .MEM_WB_misalign(mis2)
    );

    int checks = 0;
    int errors = 0;
    wb_t sbq[$];
    vec_t tab[22];

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rdn, input logic rwn);
        rd   = r;
        wr   = w;
        f3   = f;
        addr = a;
        dat  = d;
        rdst = rdn;
        rw   = rwn;
        m2r  = r;
    endtask

    // Drives one access into the wait-state instance and follows its
    // stall pattern (1,1,0), bubbles, and final MEM/WB capture.
    task automatic wait_access(input string name, input logic [31:0] a,
                               input logic [4:0] rdn,
                               input logic [31:0] exp);
        wb_t e;
        int  n;
        logic [2:0] pat;
        pat = 3'b011;
        drive(1'b1, 1'b0, 3'b010, a, 32'h0, rdn, 1'b1);
        sbq.push_back('{1'b1, 1'b1, exp, a, rdn, 1'b0});
        #1;
        for (int c = 0; c < 3; c++) begin
            chk({name, "_stall"}, {71'h0, s2}, {71'h0, pat[c]});
            if (c > 0)
                chk({name, "_bubble"}, wb2, '0);
            if (c == 2)
                chk({name, "_mdata"}, {40'h0, md2}, {40'h0, exp});
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        n = 0;
        while (s2 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (s2)
            chk({name, "_timeout"}, {71'h0, s2}, 72'h0);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({name, "_wb"}, wb2, e);
    endtask

    initial begin
        tab[0]  = '{1, 0, 3'b010, 32'h10, 32'h0, 5'd1, 1, 32'h4, 0, 1};
        tab[1]  = '{0, 1, 3'b010, 32'h20, 32'h800000F0, 5'd0, 0, 32'h0, 0, 0};
        tab[2]  = '{1, 0, 3'b000, 32'h20, 32'h0, 5'd2, 1, 32'hFFFFFFF0, 0, 1};
        tab[3]  = '{1, 0, 3'b100, 32'h20, 32'h0, 5'd3, 1, 32'hF0, 0, 1};
        tab[4]  = '{1, 0, 3'b001, 32'h22, 32'h0, 5'd4, 1, 32'hFFFF8000, 0, 1};
        tab[5]  = '{1, 0, 3'b101, 32'h22, 32'h0, 5'd5, 1, 32'h8000, 0, 1};
        tab[6]  = '{1, 0, 3'b001, 32'h20, 32'h0, 5'd6, 1, 32'hF0, 0, 1};
        tab[7]  = '{1, 0, 3'b000, 32'h23, 32'h0, 5'd7, 1, 32'hFFFFFF80, 0, 1};
        tab[8]  = '{0, 1, 3'b000, 32'h41, 32'h123456AA, 5'd0, 0, 32'h0, 0, 0};
        tab[9]  = '{1, 0, 3'b010, 32'h40, 32'h0, 5'd8, 1, 32'h0000AA10, 0, 1};
        tab[10] = '{1, 0, 3'b101, 32'h40, 32'h0, 5'd9, 1, 32'hAA10, 0, 1};
        tab[11] = '{0, 1, 3'b001, 32'h46, 32'hFFFFBEEF, 5'd0, 0, 32'h0, 0, 0};
        tab[12] = '{1, 0, 3'b010, 32'h44, 32'h0, 5'd10, 1, 32'hBEEF0011, 0, 1};
        tab[13] = '{1, 1, 3'b010, 32'h50, 32'hCAFEBABE, 5'd11, 1, 32'h14, 0, 1};
        tab[14] = '{1, 0, 3'b010, 32'h50, 32'h0, 5'd12, 1, 32'hCAFEBABE, 0, 1};
        tab[15] = '{1, 0, 3'b010, 32'h1030, 32'h0, 5'd13, 1, 32'hC, 0, 1};
        tab[16] = '{1, 0, 3'b011, 32'h10, 32'h0, 5'd14, 1, 32'h0, 0, 1};
        tab[17] = '{0, 1, 3'b011, 32'h60, 32'hFFFFFFFF, 5'd0, 0, 32'h0, 0, 0};
        tab[18] = '{1, 0, 3'b010, 32'h60, 32'h0, 5'd15, 1, 32'h18, 0, 1};
        tab[19] = '{0, 0, 3'b000, 32'h1234, 32'h0, 5'd16, 1, 32'h0, 0, 1};
        tab[20] = '{0, 1, 3'b010, 32'h42, 32'h11223344, 5'd0, 1, 32'h0,
                    MIS, !MIS};
        tab[21] = '{1, 0, 3'b010, 32'h40, 32'h0, 5'd17, 1,
                    MIS ? 32'h0000AA10 : 32'h11223344, 0, 1};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        #12;
        chk("rst_wb0", wb0, '0);
        chk("rst_wb2", wb2, '0);
        chk("rst_stall0", {71'h0, s0}, 72'h0);
        chk("rst_stall2", {71'h0, s2}, 72'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            wb_t e;
            drive(tab[i].r, tab[i].w, tab[i].f3, tab[i].a, tab[i].d,
                  tab[i].rd, tab[i].rw);
            sbq.push_back('{tab[i].xrw, tab[i].r, tab[i].exp, tab[i].a,
                            tab[i].rd, tab[i].xmis});
            #1;
            chk($sformatf("v%0d_mdata", i), {40'h0, md0}, {40'h0, tab[i].exp});
            chk($sformatf("v%0d_stall", i), {71'h0, s0}, 72'h0);
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("v%0d_wb", i), wb0, e);
        end

        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        wait_access("ws_lw", 32'h10, 5'd5, 32'h4);
        chk("ws_restart", {71'h0, s2}, 72'h1);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        chk("ws_idle", {71'h0, s2}, 72'h0);

        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 5'd0, 1'b0);
        #1;
        chk("rs_stall1", {71'h0, s2}, 72'h1);
        @(posedge clk);
        #1;
        chk("rs_stall2", {71'h0, s2}, 72'h1);
        reset_n = 1'b0;
        #1;
        chk("rs_stall_rst", {71'h0, s2}, 72'h0);
        chk("rs_wb_rst", wb2, '0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_access("rs_lw", 32'h20, 5'd6, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
